// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - scatters per-lane nibbles into 8 slots and emits 32-bit words
// A word leaves when all slots are filled or when a flush arrives with a partial mask.
module nibble_packer #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*LANES-1:0]   nibble_in,
  input  logic [3*LANES-1:0]   pos,
  input  logic [LANES-1:0]     lane_valid,
  input  logic                 in_valid,
  input  logic                 flush,
  output logic                 in_ready,
  output logic [31:0]          data_out,
  output logic [7:0]           out_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overwrite,
  output logic [7:0]           word_cnt
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, state_next;
  logic [31:0] asm_q;
  logic [7:0]  fm_q;

  logic [31:0] post_asm;
  logic [7:0]  post_fm;
  logic [2:0]  slot;
  logic        hit;
  logic        out_free;
  logic        accept;
  logic        beat_emit;
  logic        solo_emit;
  logic        emit;
  logic [31:0] emit_asm;
  logic [7:0]  emit_fm;
  logic [31:0] fill_bits;

  assign out_free = !out_valid || out_ready;
  assign in_ready = !reset && out_free;
  assign accept   = in_valid && in_ready;

  // Lanes apply in index order so the highest lane wins a shared slot; the running
  // mask catches both same-beat collisions and writes over earlier beats.
  always_comb begin
    post_asm = asm_q;
    post_fm  = fm_q;
    hit      = 1'b0;
    slot     = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i]) begin
        slot = pos[3*i +: 3];
        if (post_fm[slot]) hit = 1'b1;
        post_asm[4*slot +: 4] = nibble_in[4*i +: 4];
        post_fm[slot] = 1'b1;
      end
    end
  end

  assign beat_emit = accept && ((post_fm == 8'hFF) || (flush && (post_fm != 8'h00)));
  assign solo_emit = !in_valid && flush && (state == FILL) && out_free;
  assign emit      = beat_emit || solo_emit;
  assign emit_asm  = accept ? post_asm : asm_q;
  assign emit_fm   = accept ? post_fm : fm_q;

  always_comb begin
    fill_bits = 32'd0;
    for (int k = 0; k < 8; k++) fill_bits[4*k +: 4] = {4{emit_fm[k]}};
  end

  always_comb begin
    state_next = state;
    if (emit)
      state_next = IDLE;
    else if (accept && (post_fm != 8'h00))
      state_next = FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q     <= 32'd0;
      fm_q      <= 8'd0;
      data_out  <= 32'd0;
      out_mask  <= 8'd0;
      out_valid <= 1'b0;
      overwrite <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      overwrite <= accept && hit;
      if (emit) begin
        data_out  <= emit_asm & fill_bits;
        out_mask  <= emit_fm;
        out_valid <= 1'b1;
        asm_q     <= 32'd0;
        fm_q      <= 8'd0;
        word_cnt  <= word_cnt + 8'd1;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (accept) begin
          asm_q <= post_asm;
          fm_q  <= post_fm;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - vector table, directed corner sequences and random run vs slot model
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] nibble_in;
  logic [11:0] pos;
  logic [3:0]  lane_valid;
  logic        in_valid;
  logic        flush;
  logic        in_ready;
  logic [31:0] data_out;
  logic [7:0]  out_mask;
  logic        out_valid;
  logic        out_ready;
  logic        overwrite;
  logic [7:0]  word_cnt;

  int errors = 0;
  int checks = 0;

  nibble_packer #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .nibble_in(nibble_in), .pos(pos), .lane_valid(lane_valid),
    .in_valid(in_valid), .flush(flush), .in_ready(in_ready), .data_out(data_out),
    .out_mask(out_mask), .out_valid(out_valid), .out_ready(out_ready),
    .overwrite(overwrite), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference: eight slots with a filled flag each, plus the output register.
  logic [3:0]  m_data [8];
  bit          m_fill [8];
  logic [31:0] m_dout = 32'd0;
  logic [7:0]  m_mask = 8'd0;
  bit          m_ov = 1'b0;
  bit          m_ow = 1'b0;
  logic [7:0]  m_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_data[k] = 4'd0;
      m_fill[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit rdy, acc, any, all_f, ow, em;
    int p;
    if (reset) begin
      model_clear();
      m_dout = 32'd0; m_mask = 8'd0; m_ov = 1'b0; m_ow = 1'b0; m_cnt = 8'd0;
      return;
    end
    rdy = !m_ov || out_ready;
    acc = in_valid && rdy;
    ow  = 1'b0;
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_valid[i]) begin
          p = int'(pos[3*i +: 3]);
          if (m_fill[p]) ow = 1'b1;
          m_data[p] = nibble_in[4*i +: 4];
          m_fill[p] = 1'b1;
        end
      end
    end
    any = 1'b0; all_f = 1'b1;
    for (int k = 0; k < 8; k++) begin
      any   = any | m_fill[k];
      all_f = all_f & m_fill[k];
    end
    em = (acc && (all_f || (flush && any))) || (!in_valid && flush && any && rdy);
    if (m_ov && out_ready) m_ov = 1'b0;
    if (em) begin
      m_dout = 32'd0;
      m_mask = 8'd0;
      for (int k = 0; k < 8; k++) begin
        if (m_fill[k]) begin
          m_dout = m_dout | (32'(m_data[k]) << (4 * k));
          m_mask[k] = 1'b1;
        end
      end
      m_ov  = 1'b1;
      m_cnt = m_cnt + 8'd1;
      model_clear();
    end
    m_ow = acc && ow;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !reset && (!m_ov || out_ready)});
    @(posedge clk);
    model_edge();
    #1;
    chk("data_out", data_out, m_dout);
    chk("out_mask", {24'd0, out_mask}, {24'd0, m_mask});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("overwrite", {31'd0, overwrite}, {31'd0, m_ow});
    chk("word_cnt", {24'd0, word_cnt}, {24'd0, m_cnt});
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [3:0] lv, input logic [15:0] nib,
                       input logic [11:0] p, input logic fl, input logic ordy);
    in_valid = iv; lane_valid = lv; nibble_in = nib; pos = p; flush = fl; out_ready = ordy;
  endtask

  typedef struct {
    logic        iv;
    logic [3:0]  lv;
    logic [15:0] nib;
    logic [11:0] p;
    logic        fl;
    logic        ordy;
    logic [31:0] e_data;
    logic [7:0]  e_mask;
    logic        e_ov;
    logic        e_ow;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{1'b1, 4'hF, 16'h3210, 12'h688, 1'b0, 1'b1, 32'h00000000, 8'h00, 1'b0, 1'b0, 8'd0};
    vt[1] = '{1'b1, 4'hF, 16'h7654, 12'hFAC, 1'b0, 1'b1, 32'h76543210, 8'hFF, 1'b1, 1'b0, 8'd1};
    vt[2] = '{1'b1, 4'h3, 16'h00BA, 12'h015, 1'b1, 1'b1, 32'h00A00B00, 8'h24, 1'b1, 1'b0, 8'd2};
    vt[3] = '{1'b1, 4'h9, 16'h9001, 12'h000, 1'b1, 1'b1, 32'h00000009, 8'h01, 1'b1, 1'b1, 8'd3};
    vt[4] = '{1'b0, 4'h0, 16'h0000, 12'h000, 1'b0, 1'b1, 32'h00000009, 8'h01, 1'b0, 1'b0, 8'd3};
    vt[5] = '{1'b0, 4'h0, 16'h0000, 12'h000, 1'b1, 1'b1, 32'h00000009, 8'h01, 1'b0, 1'b0, 8'd3};
    vt[6] = '{1'b1, 4'h0, 16'h5555, 12'h000, 1'b0, 1'b1, 32'h00000009, 8'h01, 1'b0, 1'b0, 8'd3};
    vt[7] = '{1'b1, 4'h1, 16'h0005, 12'h003, 1'b0, 1'b1, 32'h00000009, 8'h01, 1'b0, 1'b0, 8'd3};
    vt[8] = '{1'b1, 4'h1, 16'h000C, 12'h003, 1'b1, 1'b1, 32'h0000C000, 8'h08, 1'b1, 1'b1, 8'd4};

    model_clear();
    reset = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 12'h0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    step();
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      drive(vt[v].iv, vt[v].lv, vt[v].nib, vt[v].p, vt[v].fl, vt[v].ordy);
      step();
      chk($sformatf("vec%0d_data", v), data_out, vt[v].e_data);
      chk($sformatf("vec%0d_mask", v), {24'd0, out_mask}, {24'd0, vt[v].e_mask});
      chk($sformatf("vec%0d_ov", v), {31'd0, out_valid}, {31'd0, vt[v].e_ov});
      chk($sformatf("vec%0d_ow", v), {31'd0, overwrite}, {31'd0, vt[v].e_ow});
      chk($sformatf("vec%0d_cnt", v), {24'd0, word_cnt}, {24'd0, vt[v].e_cnt});
    end

    // Backpressure: word 0000C000 is held while beats are offered.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'hF, 16'(c * 16'h1111), 12'h688, 1'b1, 1'b0);
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_data_hold", data_out, 32'h0000C000);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b1, 4'hF, 16'hDCBA, 12'h688, 1'b1, 1'b1);
    step();
    chk("bp_new_word", data_out, 32'h0000DCBA);
    chk("bp_new_mask", {24'd0, out_mask}, 32'h0F);
    chk("bp_valid_kept", {31'd0, out_valid}, 32'd1);

    // Reset in the middle of a partial word.
    drive(1'b1, 4'hF, 16'h1111, 12'h688, 1'b0, 1'b1);
    step();
    reset = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 12'h0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b1, 4'hF, 16'hFEDC, 12'h688, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'hF, 16'hBA98, 12'hFAC, 1'b0, 1'b1);
    step();
    chk("rmf_data", data_out, 32'hBA98FEDC);
    chk("rmf_cnt", {24'd0, word_cnt}, 32'd1);

    // Counter wrap after 256 emitted words from reset.
    reset = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 12'h0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    for (int w = 0; w < 256; w++) begin
      drive(1'b1, 4'h1, 16'(w), 12'(w % 8), 1'b1, 1'b1);
      step();
      if (w == 254) chk("wrap_255", {24'd0, word_cnt}, 32'd255);
    end
    chk("wrap_0", {24'd0, word_cnt}, 32'd0);

    // Random traffic against the slot model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 9) < 7, 4'($urandom), 16'($urandom), 12'($urandom),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter LANES, default 4, number of nibble input lanes per beat; only value 4 is supported.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 NIBBLE_IN  input  16  lane i nibble at [4i+3:4i].
REQ-005 POS  input  12  lane i destination slot (0..7) at [3i+2:3i]; slot k is DATA_OUT[4k+3:4k].
REQ-006 LANE_VALID  input  4  per-lane write enable, qualified by beat accept.
REQ-007 IN_VALID  input  1  beat present.
REQ-008 FLUSH  input  1  emit the partial word; sampled only when IN_VALID && IN_READY, or when IN_VALID is low.
REQ-009 IN_READY  output  1  beat can be accepted this cycle.
REQ-010 DATA_OUT  output  32  assembled word.
REQ-011 OUT_MASK  output  8  filled slots of DATA_OUT.
REQ-012 OUT_VALID  output  1  DATA_OUT/OUT_MASK valid.
REQ-013 OUT_READY  input  1  consumer takes word when OUT_VALID && OUT_READY.
REQ-014 OVERWRITE  output  1  one-cycle pulse: accepted beat wrote an already-filled slot.
REQ-015 WORD_CNT  output  8  number of words emitted, modulo 256.

Function
REQ-016 Internal assembly register ASM[31:0] and fill mask FM[7:0]; FSM states IDLE (FM==0) and FILL (FM!=0).
REQ-017 IN_READY = !RESET && (!OUT_VALID || OUT_READY), combinational.
REQ-018 Accepted beat: for each lane i with LANE_VALID[i], ASM slot POS_i <= NIBBLE_i and FM[POS_i] <= 1.
REQ-019 Two lanes targeting the same slot in one beat: higher lane index wins; OVERWRITE pulses.
REQ-020 Lane writing a slot with FM bit already set: data replaced; OVERWRITE pulses the next cycle.
REQ-021 Completion: when FM after the beat's writes is 8'hFF, or FLUSH is set on the accepted beat with the post-beat mask nonzero, the word is emitted.
REQ-022 Emit: DATA_OUT <= post-beat ASM with unfilled slots forced to 0; OUT_MASK <= post-beat mask; OUT_VALID <= 1; ASM and FM cleared; FSM -> IDLE; WORD_CNT increments.
REQ-023 Latency: the word is visible on DATA_OUT the cycle after the completing beat is accepted.
REQ-024 Standalone FLUSH (IN_VALID low) in FILL with output free (!OUT_VALID || OUT_READY): emits the current ASM/FM per REQ-022.
REQ-025 Standalone FLUSH in FILL with output not free: ignored; the producer re-asserts it.
REQ-026 FLUSH with mask zero (IDLE, no lane writes): no emit, no count change.
REQ-027 Accepted beat with LANE_VALID=0 and no FLUSH: no state change.
REQ-028 OUT_VALID && OUT_READY with no new emit: OUT_VALID <= 0 and DATA_OUT holds its value.
REQ-029 Pop and emit in the same cycle: the new word replaces the old one and OUT_VALID stays 1, giving full throughput.
REQ-030 While OUT_VALID && !OUT_READY: DATA_OUT and OUT_MASK are stable and no beat is accepted.
REQ-031 WORD_CNT wraps from 255 to 0.

Reset
REQ-032 RESET high at a clock edge: ASM=0, FM=0, FSM=IDLE, DATA_OUT=0, OUT_MASK=0, OUT_VALID=0, OVERWRITE=0, WORD_CNT=0.
REQ-033 IN_READY is 0 while RESET is high.
REQ-034 Reset mid-operation discards any partial word and any unconsumed output word; no emit occurs on that edge.

Verification
REQ-035 Full word in two beats: beat 1 NIBBLE_IN=16'h3210, POS={3'd3,3'd2,3'd1,3'd0}, LANE_VALID=F; beat 2 NIBBLE_IN=16'h7654, POS={7,6,5,4}; OUT_READY=1 -> one cycle after beat 2: DATA_OUT=32'h76543210, OUT_MASK=FF, OUT_VALID=1, WORD_CNT=1.
REQ-036 Partial flush: one beat with lanes 0..1 only, NIBBLE_IN=16'h00BA, POS slots 5 and 2, FLUSH=1 -> DATA_OUT=32'h00A00B00, OUT_MASK=8'h24.
REQ-037 Same-slot collision: lanes 0 and 3 both target slot 0 with nibbles 1 and 9 -> slot 0 = 9 and OVERWRITE pulses for one cycle.
REQ-038 Backpressure: word held with OUT_READY=0 for 5 cycles -> IN_READY=0 and DATA_OUT stable; then OUT_READY=1 with a completing beat -> new word the next cycle and OUT_VALID never drops.
REQ-039 Reset mid-fill: 4 slots filled, RESET for 1 cycle, then fill 8 fresh slots -> the emitted word contains only the fresh nibbles and WORD_CNT=1.
REQ-040 Counter wrap: emit 256 words -> WORD_CNT returns to 0.
